// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and the load/store unit.
// Default policy is LSU priority with an IF starvation guard; define ARB_ROUND_ROBIN_EN for
// a round-robin policy instead.
module mem_port_arbiter #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            if_req_valid,
  output logic            if_req_ready,
  input  logic [AW-1:0]   if_addr,
  input  logic            if_flush,
  output logic            if_rsp_valid,
  output logic [DW-1:0]   if_rsp_data,

  input  logic            lsu_req_valid,
  output logic            lsu_req_ready,
  input  logic            lsu_we,
  input  logic [AW-1:0]   lsu_addr,
  input  logic [DW-1:0]   lsu_wdata,
  input  logic [DW/8-1:0] lsu_wstrb,
  output logic            lsu_rsp_valid,
  output logic [DW-1:0]   lsu_rsp_data,

  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  input  logic            mem_rsp_valid,
  input  logic [DW-1:0]   mem_rsp_data,

  output logic            busy,
  output logic            owner
);

  localparam int unsigned SW = DW / 8;

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e          state_q;
  logic            owner_q;
  logic            drop_q;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [SW-1:0]   wstrb_q;
  logic            if_rsp_valid_q;
  logic [DW-1:0]   if_rsp_data_q;
  logic            lsu_rsp_valid_q;
  logic [DW-1:0]   lsu_rsp_data_q;

  logic grant_if;
  logic grant_lsu;
  logic idle;

`ifdef ARB_ROUND_ROBIN_EN
  // Pointer holds the last winner; resets to IF so the LSU wins the first conflict.
  logic last_lsu_q;

  always_comb begin
    grant_lsu = lsu_req_valid && (!if_req_valid || !last_lsu_q);
    grant_if  = if_req_valid && !grant_lsu;
  end
`else
  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_q;
  logic          if_starved;

  always_comb begin
    if_starved = if_req_valid && (starve_q == CW'(STARVE_MAX));
    grant_lsu  = lsu_req_valid && !if_starved;
    grant_if   = if_req_valid && !grant_lsu;
  end
`endif

  assign idle          = (state_q == StIdle);
  assign if_req_ready  = idle && !rst && grant_if;
  assign lsu_req_ready = idle && !rst && grant_lsu;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      owner_q         <= 1'b0;
      drop_q          <= 1'b0;
      we_q            <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      wstrb_q         <= '0;
      if_rsp_valid_q  <= 1'b0;
      if_rsp_data_q   <= '0;
      lsu_rsp_valid_q <= 1'b0;
      lsu_rsp_data_q  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_lsu_q      <= 1'b0;
`else
      starve_q        <= '0;
`endif
    end else begin
      if_rsp_valid_q  <= 1'b0;
      lsu_rsp_valid_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (if_req_ready || lsu_req_ready) begin
            state_q <= StIssue;
            owner_q <= lsu_req_ready;
            drop_q  <= 1'b0;
            if (lsu_req_ready) begin
              we_q    <= lsu_we;
              addr_q  <= lsu_addr;
              wdata_q <= lsu_wdata;
              wstrb_q <= lsu_wstrb;
            end else begin
              we_q    <= 1'b0;
              addr_q  <= if_addr;
              wdata_q <= '0;
              wstrb_q <= '0;
            end
          end
        end
        StIssue: begin
          if (!owner_q && if_flush) drop_q <= 1'b1;
          if (mem_req_ready) state_q <= StResp;
        end
        StResp: begin
          if (!owner_q && if_flush) drop_q <= 1'b1;
          if (mem_rsp_valid) begin
            state_q <= StIdle;
            if (owner_q) begin
              lsu_rsp_valid_q <= 1'b1;
              lsu_rsp_data_q  <= we_q ? '0 : mem_rsp_data;
            end else if (!drop_q && !if_flush) begin
              // A flush in the completing cycle still suppresses the response.
              if_rsp_valid_q <= 1'b1;
              if_rsp_data_q  <= mem_rsp_data;
            end
          end
        end
        default: state_q <= StIdle;
      endcase

`ifdef ARB_ROUND_ROBIN_EN
      if (if_req_ready || lsu_req_ready) last_lsu_q <= lsu_req_ready;
`else
      if (if_req_ready) begin
        starve_q <= '0;
      end else if (lsu_req_ready && if_req_valid && (starve_q != CW'(STARVE_MAX))) begin
        starve_q <= starve_q + 1'b1;
      end
`endif
    end
  end

  assign mem_req_valid = (state_q == StIssue);
  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_wstrb     = wstrb_q;
  assign if_rsp_valid  = if_rsp_valid_q;
  assign if_rsp_data   = if_rsp_data_q;
  assign lsu_rsp_valid = lsu_rsp_valid_q;
  assign lsu_rsp_data  = lsu_rsp_data_q;
  assign busy          = !idle;
  assign owner         = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios, then randomized traffic checked by a
// transaction-level reference model feeding a scoreboard that a separate monitor drains.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned SM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_valid, if_req_ready, if_flush, if_rsp_valid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rsp_data;
  logic          lsu_req_valid, lsu_req_ready, lsu_we, lsu_rsp_valid;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata, lsu_rsp_data;
  logic [SW-1:0] lsu_wstrb;
  logic          mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rsp_data;
  logic [SW-1:0] mem_wstrb;
  logic          busy, owner;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
    .clk           (clk),
    .rst           (rst),
    .if_req_valid  (if_req_valid),
    .if_req_ready  (if_req_ready),
    .if_addr       (if_addr),
    .if_flush      (if_flush),
    .if_rsp_valid  (if_rsp_valid),
    .if_rsp_data   (if_rsp_data),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_we        (lsu_we),
    .lsu_addr      (lsu_addr),
    .lsu_wdata     (lsu_wdata),
    .lsu_wstrb     (lsu_wstrb),
    .lsu_rsp_valid (lsu_rsp_valid),
    .lsu_rsp_data  (lsu_rsp_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .busy          (busy),
    .owner         (owner)
  );

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
  } req_t;

  typedef struct packed {
    logic          is_if;
    logic          drop;
    logic [DW-1:0] data;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];
  logic sb_en = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req_valid  = 1'b0;
    if_addr       = '0;
    if_flush      = 1'b0;
    lsu_req_valid = 1'b0;
    lsu_we        = 1'b0;
    lsu_addr      = '0;
    lsu_wdata     = '0;
    lsu_wstrb     = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  // Monitor: checks every memory request and every response the DUT presents.
  initial begin
    rsp_t e;
    req_t r;
    forever begin
      @(posedge clk);
      #2;
      if (sb_en) begin
        if (mem_req_valid) begin
          if (req_q.size() == 0) begin
            chk("mem_req_unexpected", mem_req_valid, 1'b0);
          end else begin
            r = req_q[0];
            chk("mem_we", mem_we, r.we);
            chk("mem_addr", mem_addr, r.addr);
            chk("mem_wdata", mem_wdata, r.wdata);
            chk("mem_wstrb", mem_wstrb, r.wstrb);
            if (mem_req_ready) req_q.delete(0);
          end
        end
        if (rsp_q.size() > 0) begin
          e = rsp_q.pop_front();
          chk("if_rsp_valid", if_rsp_valid, e.is_if && !e.drop);
          chk("lsu_rsp_valid", lsu_rsp_valid, !e.is_if);
          if (e.is_if && !e.drop) chk("if_rsp_data", if_rsp_data, e.data);
          if (!e.is_if) chk("lsu_rsp_data", lsu_rsp_data, e.data);
        end else if (if_rsp_valid || lsu_rsp_valid) begin
          chk("rsp_unexpected", {if_rsp_valid, lsu_rsp_valid}, 2'b00);
        end
      end
    end
  end

  // Reference model state: requester queues of depth one, transaction phase, policy memory.
  logic          if_pend, lsu_pend;
  logic [AW-1:0] i_addr, l_addr;
  logic          l_we;
  logic [DW-1:0] l_wdata;
  logic [SW-1:0] l_wstrb;
  int            phase;    // 0 no transaction, 1 waiting for memory accept, 2 waiting for data
  logic          cur_lsu, cur_we, drop;
  int            if_losses;
  logic          last_lsu;

  task automatic model_reset();
    if_pend   = 1'b0;
    lsu_pend  = 1'b0;
    phase     = 0;
    cur_lsu   = 1'b0;
    cur_we    = 1'b0;
    drop      = 1'b0;
    if_losses = 0;
    last_lsu  = 1'b0;
  endtask

  task automatic drive_random(input logic gen);
    if (gen && !if_pend && $urandom_range(0, 2) != 0) begin
      if_pend = 1'b1;
      i_addr  = $urandom;
    end
    if (gen && !lsu_pend && $urandom_range(0, 2) != 0) begin
      lsu_pend = 1'b1;
      l_we     = 1'($urandom_range(0, 1));
      l_addr   = $urandom;
      l_wdata  = $urandom;
      l_wstrb  = SW'($urandom);
    end
    if_req_valid  = if_pend;
    if_addr       = i_addr;
    lsu_req_valid = lsu_pend;
    lsu_we        = l_we;
    lsu_addr      = l_addr;
    lsu_wdata     = l_wdata;
    lsu_wstrb     = l_wstrb;
    mem_req_ready = 1'($urandom_range(0, 1));
    mem_rsp_valid = (phase == 2) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
    mem_rsp_data  = $urandom;
    if_flush      = ($urandom_range(0, 7) == 0);
  endtask

  task automatic model_cycle();
    logic exp_if, exp_lsu;
    req_t r;
    rsp_t e;
    exp_if  = 1'b0;
    exp_lsu = 1'b0;
    if (phase == 0) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_lsu = lsu_pend && !(if_pend && last_lsu);
`else
      exp_lsu = lsu_pend && !(if_pend && if_losses >= int'(SM));
`endif
      exp_if = if_pend && !exp_lsu;
    end
    chk("if_req_ready", if_req_ready, exp_if);
    chk("lsu_req_ready", lsu_req_ready, exp_lsu);
    chk("busy", busy, phase != 0);
    chk("mem_req_valid_phase", mem_req_valid, phase == 1);
    if (phase != 0) chk("owner", owner, cur_lsu);

    if (exp_if || exp_lsu) begin
`ifdef ARB_ROUND_ROBIN_EN
      last_lsu = exp_lsu;
`else
      if (exp_if) if_losses = 0;
      else if (if_pend && if_losses < int'(SM)) if_losses++;
`endif
      cur_lsu = exp_lsu;
      cur_we  = exp_lsu && l_we;
      drop    = 1'b0;
      phase   = 1;
      r.we    = cur_we;
      r.addr  = exp_lsu ? l_addr : i_addr;
      r.wdata = exp_lsu ? l_wdata : '0;
      r.wstrb = exp_lsu ? l_wstrb : '0;
      req_q.push_back(r);
      if (exp_lsu) lsu_pend = 1'b0;
      else if_pend = 1'b0;
    end else if (phase != 0) begin
      if (!cur_lsu && if_flush) drop = 1'b1;
      if (phase == 1 && mem_req_ready) begin
        phase = 2;
      end else if (phase == 2 && mem_rsp_valid) begin
        e.is_if = !cur_lsu;
        e.drop  = drop;
        e.data  = cur_we ? '0 : mem_rsp_data;
        rsp_q.push_back(e);
        phase = 0;
      end
    end
  endtask

  logic grants[$];

  initial begin
    logic exp_order[6];
    int   cyc;

    rst = 1'b1;
    model_reset();
    do_reset();

    // Reset state with idle inputs.
    @(negedge clk);
    chk("reset_outputs", |{if_req_ready, if_rsp_valid, if_rsp_data, lsu_req_ready, lsu_rsp_valid,
        lsu_rsp_data, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb, busy, owner}, 1'b0);

    // Single IF read, memory answers one cycle after the handshake.
    step();
    if_req_valid = 1'b1;
    if_addr      = 32'h100;
    @(negedge clk);
    chk("t2_if_ready", if_req_ready, 1'b1);
    chk("t2_lsu_ready", lsu_req_ready, 1'b0);
    step();
    if_req_valid  = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    chk("t2_mem_valid", mem_req_valid, 1'b1);
    chk("t2_mem_addr", mem_addr, 32'h100);
    chk("t2_mem_we", mem_we, 1'b0);
    chk("t2_busy_1", busy, 1'b1);
    chk("t2_owner", owner, 1'b0);
    step();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hDEADBEEF;
    @(negedge clk);
    chk("t2_busy_2", busy, 1'b1);
    chk("t2_mem_valid_off", mem_req_valid, 1'b0);
    step();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("t2_rsp_valid", if_rsp_valid, 1'b1);
    chk("t2_rsp_data", if_rsp_data, 32'hDEADBEEF);
    chk("t2_busy_done", busy, 1'b0);
    step();
    @(negedge clk);
    chk("t2_rsp_pulse_end", if_rsp_valid, 1'b0);

    // LSU store with the memory stalling three cycles.
    step();
    lsu_req_valid = 1'b1;
    lsu_we        = 1'b1;
    lsu_addr      = 32'h40;
    lsu_wdata     = 32'h12345678;
    lsu_wstrb     = 4'b0011;
    @(negedge clk);
    chk("t4_lsu_ready", lsu_req_ready, 1'b1);
    chk("t4_if_ready", if_req_ready, 1'b0);
    step();
    lsu_req_valid = 1'b0;
    lsu_wdata     = 32'hFFFFFFFF;
    lsu_addr      = 32'hFFFFFFFF;
    lsu_wstrb     = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_mem_valid", mem_req_valid, 1'b1);
      chk("t4_mem_we", mem_we, 1'b1);
      chk("t4_mem_addr", mem_addr, 32'h40);
      chk("t4_mem_wdata", mem_wdata, 32'h12345678);
      chk("t4_mem_wstrb", mem_wstrb, 4'b0011);
      step();
      mem_req_ready = (i == 2);
    end
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hCAFEF00D;
    @(negedge clk);
    chk("t4_rsp_early", lsu_rsp_valid, 1'b0);
    step();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("t4_rsp_valid", lsu_rsp_valid, 1'b1);
    chk("t4_rsp_data", lsu_rsp_data, 32'h0);
    chk("t4_if_rsp", if_rsp_valid, 1'b0);
    step();
    @(negedge clk);
    chk("t4_rsp_pulse_end", lsu_rsp_valid, 1'b0);

    // Reset while an IF read waits for data; a late memory response is ignored.
    step();
    if_req_valid = 1'b1;
    if_addr      = 32'h200;
    @(negedge clk);
    chk("t3_if_ready", if_req_ready, 1'b1);
    step();
    if_req_valid  = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    rst           = 1'b1;
    @(negedge clk);
    chk("t3_busy_resp", busy, 1'b1);
    step();
    rst           = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hBAD0BAD0;
    @(negedge clk);
    chk("t3_busy_after_rst", busy, 1'b0);
    step();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("t3_outputs_zero", |{if_req_ready, if_rsp_valid, if_rsp_data, lsu_req_ready, lsu_rsp_valid,
        lsu_rsp_data, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb, busy, owner}, 1'b0);

    // IF read flushed while waiting for data; a queued LSU load goes next.
    step();
    if_req_valid = 1'b1;
    if_addr      = 32'h300;
    @(negedge clk);
    chk("t6_if_ready", if_req_ready, 1'b1);
    step();
    if_req_valid  = 1'b0;
    lsu_req_valid = 1'b1;
    lsu_we        = 1'b0;
    lsu_addr      = 32'h44;
    mem_req_ready = 1'b1;
    @(negedge clk);
    chk("t6_lsu_blocked_issue", lsu_req_ready, 1'b0);
    step();
    mem_req_ready = 1'b0;
    if_flush      = 1'b1;
    step();
    if_flush      = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h55;
    @(negedge clk);
    chk("t6_lsu_blocked_resp", lsu_req_ready, 1'b0);
    step();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("t6_if_rsp_dropped", if_rsp_valid, 1'b0);
    chk("t6_lsu_ready_next_idle", lsu_req_ready, 1'b1);
    chk("t6_busy", busy, 1'b0);
    step();
    lsu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    chk("t6_owner_lsu", owner, 1'b1);
    chk("t6_if_rsp_still_off", if_rsp_valid, 1'b0);
    step();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h77;
    step();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("t6_lsu_rsp_valid", lsu_rsp_valid, 1'b1);
    chk("t6_lsu_rsp_data", lsu_rsp_data, 32'h77);

    // Grant order with both requesters asserting continuously.
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`endif
    do_reset();
    if_req_valid  = 1'b1;
    if_addr       = 32'h500;
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'h600;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    for (int c = 0; c < 60 && grants.size() < 6; c++) begin
      @(negedge clk);
      if (if_req_ready) grants.push_back(1'b0);
      if (lsu_req_ready) grants.push_back(1'b1);
      step();
    end
    chk("t5_grant_count", grants.size(), 6);
    for (int k = 0; k < 6 && k < grants.size(); k++) begin
      chk($sformatf("t5_grant_%0d_is_lsu", k), grants[k], exp_order[k]);
    end
    if_req_valid  = 1'b0;
    lsu_req_valid = 1'b0;
    repeat (4) step();

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    sb_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      drive_random(1'b1);
      @(negedge clk);
      model_cycle();
      step();
    end
    cyc = 0;
    while ((if_pend || lsu_pend || phase != 0) && cyc < 300) begin
      drive_random(1'b0);
      @(negedge clk);
      model_cycle();
      step();
      cyc++;
    end
    idle_inputs();
    @(negedge clk);
    chk("drain_busy", {busy, if_req_valid, lsu_req_valid}, 3'b000);
    step();
    step();
    chk("req_q_drained", req_q.size(), 0);
    sb_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified memory between the instruction-fetch (IF) stage and the load/store unit (LSU) of the pipeline.
- Accepts one request at a time from either requester and issues it to memory with a valid/ready handshake.
- Routes the memory response back to the requester that owns the transaction.
- Default policy: fixed LSU priority, with a starvation guard for IF.

Parameters:
- AW, 32, address width.
- DW, 32, data width (multiple of 8).
- STARVE_MAX, 4, consecutive lost IF arbitrations before IF is forced to win (>=1).

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- if_req_valid  in  1  IF read request.
- if_req_ready  out  1  IF request accepted this cycle.
- if_addr  in  AW  IF read address.
- if_flush  in  1  discard any outstanding IF response.
- if_rsp_valid  out  1  IF read data valid, one-cycle pulse.
- if_rsp_data  out  DW  IF read data.
- lsu_req_valid  in  1  LSU request.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_we  in  1  1 = store, 0 = load.
- lsu_addr  in  AW  LSU address.
- lsu_wdata  in  DW  store data.
- lsu_wstrb  in  DW/8  store byte enables.
- lsu_rsp_valid  out  1  load data / store ack, one-cycle pulse.
- lsu_rsp_data  out  DW  load data (0 for store ack).
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts request.
- mem_we, mem_addr, mem_wdata, mem_wstrb  out  1/AW/DW/DW/8  latched request fields.
- mem_rsp_valid  in  1  memory response; issued for both reads and writes.
- mem_rsp_data  in  DW  memory read data.
- busy  out  1  transaction in flight (state != IDLE).
- owner  out  1  0 = IF, 1 = LSU; owner of the current transaction.

Behaviour:
- Reset (rst=1 at posedge): state goes to IDLE; starve_cnt=0; every output 0, including data outputs. Takes effect mid-transaction; a mem_rsp_valid arriving after reset is ignored.
- FSM states: IDLE, ISSUE, RESP.
- IDLE arbitration (combinational, same cycle):
  - LSU wins if lsu_req_valid, unless IF is starved.
  - IF is starved when if_req_valid && starve_cnt==STARVE_MAX.
  - If only one requester is valid, it wins.
  - Only the winner's *_req_ready is high. Both readies are 0 outside IDLE.
- On accept (valid&ready):
  - Latch addr/we/wdata/wstrb and owner. IF forces we=0, wstrb=0.
  - Next state is ISSUE.
- ISSUE: mem_req_valid=1, fields stable, until mem_req_ready. Then go to RESP.
- RESP: wait for mem_rsp_valid, then:
  - Register data into the owner's rsp_data and pulse the owner's rsp_valid on the next cycle.
  - Return to IDLE; the pulse cycle is an IDLE cycle and can accept a new request.
- Minimum latency: accept at cycle N, mem_req_valid at N+1, mem_rsp_valid at N+2 earliest, rsp_valid at N+3.
- starve_cnt:
  - +1 (saturating at STARVE_MAX) when IF is valid in IDLE and LSU wins.
  - Cleared when IF wins.
  - Unchanged otherwise.
- if_flush: while owner=IF and state is ISSUE or RESP, set a drop flag. The transaction still completes on the memory side, but if_rsp_valid is suppressed. if_flush in IDLE has no effect.
- Requesters must hold valid/fields until ready; the arbiter never retracts ready within a cycle.
- mem_rsp_valid in IDLE or ISSUE is ignored.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - Replaces LSU-priority and starvation logic with a 1-bit last-grant pointer.
  - When both requesters are valid, grant the one not granted last. Pointer updates on every accept.
  - Pointer resets to IF, so LSU wins the first conflict.
  - starve_cnt and STARVE_MAX are unused.
- Undefined: fixed LSU priority with starvation guard, as above.

Test Plan:
- Reset mid-RESP (IF owner), then mem_rsp_valid pulses after reset -> if_rsp_valid stays 0; busy=0; all outputs 0 next cycle.
- Single IF read of addr 0x100; memory responds 1 cycle after handshake with 0xDEADBEEF -> if_rsp_valid pulse at accept+3, if_rsp_data=0xDEADBEEF, owner=0, busy high for 2 cycles.
- LSU store addr 0x40, wdata 0x12345678, wstrb 4'b0011; mem_req_ready low for 3 cycles -> fields held stable; lsu_rsp_valid one pulse after the ack; lsu_rsp_data=0.
- Both valid continuously, STARVE_MAX=4, default build -> grant order LSU,LSU,LSU,LSU,IF,LSU…
- ARB_ROUND_ROBIN_EN build, same stimulus -> order LSU,IF,LSU,IF…
- IF read in flight, if_flush pulsed during RESP -> memory handshake completes, if_rsp_valid never asserts, next queued LSU request accepted in the following IDLE cycle.
